// File: rtl/ast_rl_sink_buffer.sv
// rtl/ast_rl_sink_buffer.sv - Avalon-ST sink buffer converting readyLatency N upstream to readyLatency 0 downstream
//
// Purpose:
//   Sits directly downstream of a FIFO streaming source that uses readyLatency
//   READY_LATENCY. A beat may arrive up to READY_LATENCY cycles after ready was
//   given. This block absorbs those in-flight beats in a small first-word-fall-through
//   buffer and re-presents them with plain valid/ready (latency 0) semantics.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   snk_valid    upstream beat valid
//   snk_data     upstream beat data [WIDTH-1:0]
//   snk_ready    upstream ready (a beat may follow READY_LATENCY cycles later)
//   src_valid    buffer non-empty
//   src_data     head-of-buffer data [WIDTH-1:0]
//   src_ready    downstream accept, latency 0
//   err_overrun  sticky flag: a beat arrived without a matching ready grant
//   beat_cnt     (AST_RL_SINK_STATS_EN only) accepted-beat counter, wraps
//   drop_cnt     (AST_RL_SINK_STATS_EN only) dropped-beat counter, wraps
//
// Optional feature macro: AST_RL_SINK_STATS_EN

module ast_rl_sink_buffer #(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int READY_LATENCY       = 2,
    parameter int BUF_DEPTH           = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          snk_valid,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data,
    output logic                                          snk_ready,
    output logic                                          src_valid,
    output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data,
    input  logic                                          src_ready,
    output logic                                          err_overrun
`ifdef AST_RL_SINK_STATS_EN
    ,
    output logic [15:0]                                   beat_cnt,
    output logic [7:0]                                    drop_cnt
`endif
);

    localparam int WIDTH = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW    = $clog2(BUF_DEPTH + 1);
    localparam int HW    = (READY_LATENCY > 0) ? READY_LATENCY : 1;

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic [HW-1:0]    hist;     // hist[0] = ready one cycle ago, hist[HW-1] = ready READY_LATENCY cycles ago
    logic             live;     // holds snk_ready low until the first edge after reset release
    logic [3:0]       pend;
    logic             grant;
    logic             full;
    logic             push;
    logic             drop;
    logic             pop;

    // Outstanding reservations: every ready still inside the latency window may
    // still deliver a beat, so it is counted against buffer space.
    always_comb begin
        pend = '0;
        for (int i = 0; i < READY_LATENCY; i++) begin
            pend = pend + {3'b000, hist[i]};
        end
    end

    // Purely register-decoded; pops in the current cycle are not credited so
    // there is no input-to-snk_ready path.
    assign snk_ready = live && ((8'(occ) + 8'(pend)) < 8'(BUF_DEPTH));

    generate
        if (READY_LATENCY == 0) begin : g_rl0
            assign grant = snk_ready;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist <= '0;
                end else begin
                    hist <= '0;
                end
            end
        end else if (READY_LATENCY == 1) begin : g_rl1
            assign grant = hist[0];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist <= '0;
                end else begin
                    hist <= snk_ready;
                end
            end
        end else begin : g_rln
            assign grant = hist[HW-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist <= '0;
                end else begin
                    hist <= {hist[HW-2:0], snk_ready};
                end
            end
        end
    endgenerate

    assign full      = (occ == OW'(BUF_DEPTH));
    assign src_valid = (occ != '0);
    assign src_data  = mem[rd_ptr];
    assign pop       = src_valid & src_ready;
    // The full check is a backstop: with honest credits a granted beat always
    // fits, so a beat hitting a full buffer is by definition a violation and is
    // dropped even if a pop frees a slot this same cycle.
    assign push      = snk_valid & grant & ~full;
    assign drop      = snk_valid & ~push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= snk_data;
        end
    end

    // Explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun <= 1'b0;
        end else if (drop) begin
            err_overrun <= 1'b1;
        end
    end

`ifdef AST_RL_SINK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (drop) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ast_rl_sink_buffer.md
Name: ast_rl_sink_buffer

Overview:
- Avalon-ST sink stage placed directly downstream of the FIFO's streaming source port.
- The upstream source uses readyLatency READY_LATENCY. A beat may appear READY_LATENCY cycles after ready was asserted.
- This block absorbs those in-flight beats in a small first-word-fall-through buffer.
- It re-presents the stream to the downstream consumer with readyLatency 0 valid/ready semantics.

Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per beat. WIDTH = DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
- READY_LATENCY, 2, upstream ready-to-valid latency in cycles. Legal range 0..8.
- BUF_DEPTH, 4, buffer entries. Must be >= READY_LATENCY+1. Full throughput requires >= READY_LATENCY+2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- snk_valid  input  1  upstream beat valid.
- snk_data  input  WIDTH  upstream beat data.
- snk_ready  output  1  to upstream. A beat is permitted READY_LATENCY cycles after ready is asserted.
- src_valid  output  1  buffer non-empty.
- src_data  output  WIDTH  head-of-buffer data.
- src_ready  input  1  downstream accept, latency 0.
- err_overrun  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release):
  - occupancy = 0, read/write pointers = 0, ready history = 0.
  - snk_ready = 0 while rst is high; first asserts the cycle after release.
  - src_valid = 0, src_data = 0, err_overrun = 0.
- Credit rule, evaluated at cycle t:
  - occ(t) = entries held at start of t.
  - pend(t) = count of cycles in t-READY_LATENCY..t-1 where snk_ready was 1.
  - snk_ready(t) = (occ(t)+pend(t) < BUF_DEPTH).
  - Decoded only from registered state; no combinational path from any input to snk_ready.
  - Same-cycle pops are ignored (conservative).
- Accept rule:
  - Beat accepted at t iff snk_valid(t)=1 and snk_ready(t-READY_LATENCY)=1.
  - When READY_LATENCY=0, this means snk_ready(t) itself.
  - Accepted beat is written at the tail; visible on src_* from t+1.
- Overrun:
  - snk_valid(t)=1 with no matching ready grant: beat dropped, buffer unchanged.
  - err_overrun set at t+1, held until reset.
- Output side:
  - src_valid = (occ != 0).
  - src_data = head entry, registered storage, no bypass. Pass-through latency is 1 cycle minimum.
  - Pop when src_valid & src_ready.
  - src_data is held stable while src_valid=1 and src_ready=0.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointers wrap modulo BUF_DEPTH; non-power-of-two depth must wrap explicitly.
- Full buffer: snk_ready deasserted by the credit rule, so a push to a full buffer is only possible on a protocol violation.
  - That beat is dropped and flags err_overrun, even if a pop occurs the same cycle.
- Unused grant (ready given, no valid READY_LATENCY cycles later): the reservation expires as the history shifts out. No state change.
- Reset mid-stream: in-flight reservations and buffered beats are discarded.

Optional Feature:
- Macro AST_RL_SINK_STATS_EN.
- When defined:
  - Adds output beat_cnt[15:0]: increments once per accepted beat.
  - Adds output drop_cnt[7:0]: increments once per overrun-dropped beat.
  - Both wrap, reset to 0.
- When undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, upstream drives valid exactly READY_LATENCY after each ready, data 0x00000001..0x00000014 (20 beats), src_ready=1 -> all 20 beats out in order, snk_ready never drops (BUF_DEPTH=4, RL=2), err_overrun=0.
- Same stream, src_ready=0 -> snk_ready falls once occ+pend reaches 4. Exactly 4 beats buffered, src_data=0x00000001 stable. Raise src_ready -> remaining beats out in order, none lost.
- Upstream sends valid with data 0xDEADBEEF at a cycle whose ready 2 cycles earlier was 0 -> beat absent from output, err_overrun=1 next cycle and stays 1; with macro, drop_cnt=1.
- Grants issued but upstream withholds valid for 10 cycles -> occupancy stays 0, snk_ready stays 1, no spurious src_valid.
- Buffer at 3 entries, simultaneous accept and pop on alternating src_ready -> occupancy never exceeds 4, FIFO order preserved over 50 cycles (timeout).
- Assert rst with 3 beats buffered and 2 grants pending -> src_valid=0 and err_overrun=0 immediately (async); after release the pending beats arriving are flagged as overruns.
